// File: rtl/packet_pkg.sv
// ---------------------------------------------------------------------------
// packet_pkg
//   Shared packet definitions for the switch_4port egress path.
//   Provides the default widths used by switch_port_rx and its FIFO, the
//   port-id and payload types, one-hot constants for the four switch ports
//   and a helper that classifies a port id as well-formed (exactly one bit).
// ---------------------------------------------------------------------------
package packet_pkg;

   // Default geometry of one egress receiver.
   localparam int DATA_W_DEF = 8;
   localparam int PORT_W_DEF = 4;
   localparam int DEPTH_DEF  = 8;
   localparam int CNT_W_DEF  = 16;

   // One bit per switch port; a legal id has exactly one bit set.
   typedef logic [PORT_W_DEF-1:0] port_id_t;

   // Packet payload.
   typedef logic [DATA_W_DEF-1:0] data_t;

   // A stored packet as it sits in the receive FIFO.
   typedef struct packed {
      port_id_t source;
      data_t    data;
   } packet_t;

   // One-hot identifiers of the four switch ports.
   localparam port_id_t PORT0 = 4'b0001;
   localparam port_id_t PORT1 = 4'b0010;
   localparam port_id_t PORT2 = 4'b0100;
   localparam port_id_t PORT3 = 4'b1000;

   // True when exactly one bit of the id is set. Clearing the lowest set
   // bit (id & (id - 1)) leaves zero only for powers of two.
   function automatic logic is_onehot(input port_id_t id);
      return (id != '0) && ((id & (id - port_id_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// ---------------------------------------------------------------------------
// rx_fifo
//   Synchronous first-word-fall-through FIFO used to buffer egress packets.
//   The head entry is always presented on rdata while the FIFO is not
//   empty, so a consumer sees the data in the same cycle that it sees the
//   FIFO become non-empty.
//
//   Parameters
//     WIDTH   entry width in bits
//     DEPTH   number of entries, power of two, >= 2
//
//   Ports
//     clk     in   1                 clock, posedge
//     rst_n   in   1                 asynchronous active-low reset
//     push    in   1                 write wdata at the tail
//     pop     in   1                 discard the head entry
//     wdata   in   WIDTH             entry to write
//     rdata   out  WIDTH             head entry, zero while empty
//     count   out  $clog2(DEPTH)+1   entries currently stored (registered)
//     full    out  1                 count == DEPTH (registered)
//     empty   out  1                 count == 0 (registered)
// ---------------------------------------------------------------------------
module rx_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit above the address: equal pointers
   // mean empty, pointers differing only in the wrap bit mean full.
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_next;
   logic [AW:0]      rd_next;
   logic             push_ok;
   logic             pop_ok;

   // Never pop an empty FIFO; a push into a full FIFO is only legal when
   // the head is leaving in the same cycle, which keeps the count constant.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Next pointer values; they wrap naturally modulo 2*DEPTH.
   always_comb begin
      wr_next = wr_ptr;
      rd_next = rd_ptr;
      if (push_ok) begin
         wr_next = wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
         rd_next = rd_ptr + PTR_ONE;
      end
   end

   // Pointer and status registers. count/full/empty are computed from the
   // next pointers so that all three are plain flops and agree every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         count  <= wr_next - rd_next;
         full   <= ((wr_next ^ rd_next) == FULL_XOR);
         empty  <= (wr_next == rd_next);
      end
   end

   // Storage array; contents need no reset because the pointers decide
   // what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Fall-through read of the head entry, forced to zero while empty so
   // that stale contents never appear on the outputs after reset.
   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/switch_port_rx.sv
// ---------------------------------------------------------------------------
// switch_port_rx
//   Egress receiver attached to one output port of switch_4port. Every
//   single-cycle packet presented by the switch is classified by its
//   source id, buffered in a small FWFT FIFO and handed to a host over a
//   valid/ready pop interface. Saturating statistics count stored,
//   overflow-dropped and malformed packets.
//
//   Parameters
//     DATA_W   packet payload width
//     PORT_W   one-hot port-id width
//     DEPTH    FIFO entries, power of two, >= 2
//     CNT_W    statistics counter width
//
//   Ports
//     clk          in   1                 clock, posedge
//     rst_n        in   1                 asynchronous active-low reset
//     sw_valid     in   1                 switch egress valid, one cycle per packet
//     sw_data      in   DATA_W            switch egress payload
//     sw_source    in   PORT_W            one-hot originating port
//     rx_valid     out  1                 head packet available to host
//     rx_ready     in   1                 host accepts head packet
//     rx_data      out  DATA_W            head packet payload
//     rx_source    out  PORT_W            head packet source
//     fill_level   out  $clog2(DEPTH)+1   entries stored
//     full         out  1                 fill_level == DEPTH
//     pkt_count    out  CNT_W             packets stored, saturating
//     drop_count   out  CNT_W             good packets lost to overflow, saturating
//     err_count    out  CNT_W             packets with a non-one-hot source, saturating
// ---------------------------------------------------------------------------
module switch_port_rx
   import packet_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PORT_W = PORT_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sw_valid,
   input  logic [DATA_W-1:0]        sw_data,
   input  logic [PORT_W-1:0]        sw_source,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [DATA_W-1:0]        rx_data,
   output logic [PORT_W-1:0]        rx_source,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     full,
   output logic [CNT_W-1:0]         pkt_count,
   output logic [CNT_W-1:0]         drop_count,
   output logic [CNT_W-1:0]         err_count
);

   localparam int ENTRY_W = PORT_W + DATA_W;

   logic               src_good;
   logic               good_pkt;
   logic               bad_pkt;
   logic               pop_fire;
   logic               push_en;
   logic               drop_en;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_wdata;
   logic [ENTRY_W-1:0] fifo_rdata;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == '1) ? value : value + CNT_W'(1);
   endfunction

   // A source id is well-formed when exactly one bit is set; written
   // generically so it follows PORT_W.
   assign src_good = (sw_source != '0) &&
                     ((sw_source & (sw_source - PORT_W'(1))) == '0);

   assign good_pkt = sw_valid && src_good;
   assign bad_pkt  = sw_valid && !src_good;

   // The head leaves only when the host is shown a packet and accepts it.
   assign pop_fire = rx_valid && rx_ready;

   // A full FIFO still takes a good packet if a slot frees up this cycle;
   // otherwise the packet is lost and counted as a drop. Malformed packets
   // never reach the FIFO and never count as drops, even when full.
   assign push_en = good_pkt && (!full || pop_fire);
   assign drop_en = good_pkt && full && !pop_fire;

   assign fifo_wdata = {sw_source, sw_data};

   rx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_en),
      .pop   (pop_fire),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .count (fill_level),
      .full  (full),
      .empty (fifo_empty)
   );

   // The FIFO's registered empty flag is exactly fill_level == 0, so the
   // host handshake stays consistent with fill_level every cycle.
   assign rx_valid  = !fifo_empty;
   assign rx_source = fifo_rdata[ENTRY_W-1:DATA_W];
   assign rx_data   = fifo_rdata[DATA_W-1:0];

   // Statistics; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count  <= '0;
         drop_count <= '0;
         err_count  <= '0;
      end else begin
         if (push_en) begin
            pkt_count <= sat_inc(pkt_count);
         end
         if (drop_en) begin
            drop_count <= sat_inc(drop_count);
         end
         if (bad_pkt) begin
            err_count <= sat_inc(err_count);
         end
      end
   end

endmodule
